bitlu_arbiter: RTL
==================

Name: bitlu_arbiter

Overview:
- Shares one 8-bit bitwise logic unit (AND/OR/XOR/NAND, 2-bit op select) between NUM_REQ requesters, e.g. the execute stage and a debug/DMA port.
- Round-robin grant, registered operand launch, captured result, per-requester valid/ready response handshake.
- Sits between the requesters and the logic unit; the unit itself stays purely combinational.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  single system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  request pending, one bit per requester.
- req_ready  output  NUM_REQ  one-hot accept pulse to the granted requester; combinational.
- req_bop  input  2*NUM_REQ  op per requester, requester i at bits [2i+1:2i]. Encoding: 00 AND, 01 OR, 10 XOR, 11 NAND.
- req_x  input  8*NUM_REQ  operand x, requester i at [8i+7:8i].
- req_y  input  8*NUM_REQ  operand y, same packing as req_x.
- resp_valid  output  NUM_REQ  result available, one-hot to the owning requester.
- resp_data  output  8  result byte, shared by all requesters.
- resp_ready  input  NUM_REQ  requester accepts result.
- lu_bop  output  2  op select to the logic unit; registered.
- lu_x  output  8  x operand to the logic unit; registered.
- lu_y  output  8  y operand to the logic unit; registered.
- lu_o  input  8  logic unit result.
- busy  output  1  high in any state other than IDLE.
- grant_id  output  2  index of the current or last owner.
- ops_done  output  CNT_W  count of completed response handshakes; wraps.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State=IDLE.
  - req_ready, resp_valid, resp_data, lu_bop, lu_x, lu_y, grant_id, ops_done all 0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid bit is set, pick the winner w: first set bit scanning last+1, last+2, ... modulo NUM_REQ.
  - Drive req_ready[w]=1 in that cycle only.
  - At the clock edge: lu_bop/lu_x/lu_y <= w's fields, grant_id <= w, state -> EXEC.
  - If no req_valid bit is set, stay in IDLE and keep req_ready=0.
- EXEC:
  - lu_* hold the launched operands for one cycle.
  - At the clock edge: resp_data <= lu_o, state -> RESP.
- RESP:
  - resp_valid[grant_id]=1. resp_data is held stable until the handshake completes.
  - When resp_ready[grant_id]=1 at the edge: last <= grant_id, ops_done <= ops_done+1 (wraps at 2^CNT_W), state -> IDLE.
  - resp_ready from non-owners is ignored.
  - A requester that never raises resp_ready stalls the unit indefinitely; there is no timeout.
- Latency and throughput:
  - Accept at cycle 0, resp_valid at cycle 2.
  - Fastest repeat accept is cycle 3, when resp_ready is high in cycle 2: one op per 3 cycles.
- New requests are sampled only in IDLE. req_valid arriving during EXEC or RESP waits, with req_ready=0.
- Requester protocol: hold req_valid and its operands until req_ready. Deasserting early is legal in IDLE and simply drops that requester from arbitration.
- Simultaneous requests: exactly one grant per IDLE cycle. Contending requesters are served in rotation, so no starvation: wait bounded by (NUM_REQ-1) operations.
- Width rules: outputs are a pure pass-through of the 8-bit lu_o; no arithmetic except the ops_done increment.
- lu_* keep their last values in IDLE; they are not cleared after an operation.
- Reset mid-operation: the in-flight op is discarded, no resp_valid is issued, and the pointer returns to its reset value.
- NUM_REQ < 4: grant_id upper bits never exceed NUM_REQ-1.

Test Plan:
- Reset, then req0 only, bop=00, x=F0, y=3C -> req_ready[0] pulse at cycle 0; lu_bop=00, lu_x=F0, lu_y=3C at cycle 1; resp_valid[0]=1 with resp_data=30 at cycle 2; resp_ready[0]=1 -> ops_done=1, busy=0.
- Run bop=01/10/11 on F0,3C -> resp_data FC, CC, CF respectively; ops_done=4.
- req0 and req1 both held valid, req0 bop=00 x=FF y=0F, req1 bop=10 x=AA y=55 -> grants alternate 0,1,0,1; responses 0F, FF, 0F, FF; resp_valid never asserted to a non-owner.
- Stall: hold resp_ready[0]=0 for 5 cycles while req1 is valid -> resp_valid[0] and resp_data stay constant, req_ready[1]=0 throughout; release -> req1 granted in the following IDLE cycle.
- Assert rst_n=0 asynchronously in EXEC (mid-clock) -> all outputs 0 immediately, no response after release; the next simultaneous req0+req1 grants req0.
- Complete 65536 operations -> ops_done wraps to 0.

Source files
------------

// File: rtl/bitlu_arbiter.sv
// bitlu_arbiter: round-robin sharing of one combinational 8-bit bitwise logic unit
// between NUM_REQ requesters, with registered operand launch and a held result.
module bitlu_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [2*NUM_REQ-1:0]   req_bop,
   input  logic [8*NUM_REQ-1:0]   req_x,
   input  logic [8*NUM_REQ-1:0]   req_y,
   output logic [NUM_REQ-1:0]     resp_valid,
   output logic [7:0]             resp_data,
   input  logic [NUM_REQ-1:0]     resp_ready,
   output logic [1:0]             lu_bop,
   output logic [7:0]             lu_x,
   output logic [7:0]             lu_y,
   input  logic [7:0]             lu_o,
   output logic                   busy,
   output logic [1:0]             grant_id,
   output logic [CNT_W-1:0]       ops_done
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t state;
   logic [1:0] last, win, c;
   logic any;
   logic [3:0] v4, w4, r4;
   logic [1:0] bop_a [4];
   logic [7:0] x_a [4];
   logic [7:0] y_a [4];
   // pad per-requester fields to four slots so a 2-bit index is always in range
   for (genvar g = 0; g < 4; g++) begin : g_pad
      if (g < NUM_REQ) begin : g_on
         assign v4[g] = req_valid[g];
         assign bop_a[g] = req_bop[2*g +: 2];
         assign x_a[g] = req_x[8*g +: 8];
         assign y_a[g] = req_y[8*g +: 8];
      end else begin : g_off
         assign v4[g] = 1'b0;
         assign bop_a[g] = 2'd0;
         assign x_a[g] = 8'd0;
         assign y_a[g] = 8'd0;
      end
   end
   always_comb begin
      any = 1'b0;
      win = 2'd0;
      c = last;
      for (int k = 0; k < NUM_REQ; k++) begin
         c = (c == 2'(NUM_REQ - 1)) ? 2'd0 : c + 2'd1;
         if (v4[c] && !any) begin
            any = 1'b1;
            win = c;
         end
      end
   end
   assign w4 = 4'b0001 << win;
   assign r4 = 4'b0001 << grant_id;
   assign req_ready = (state == IDLE && any) ? w4[NUM_REQ-1:0] : '0;
   assign resp_valid = (state == RESP) ? r4[NUM_REQ-1:0] : '0;
   assign busy = state != IDLE;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         last <= 2'(NUM_REQ - 1);
         lu_bop <= 2'd0;
         lu_x <= 8'd0;
         lu_y <= 8'd0;
         grant_id <= 2'd0;
         resp_data <= 8'd0;
         ops_done <= '0;
      end else begin
         case (state)
            IDLE: if (any) begin
               lu_bop <= bop_a[win];
               lu_x <= x_a[win];
               lu_y <= y_a[win];
               grant_id <= win;
               state <= EXEC;
            end
            EXEC: begin
               resp_data <= lu_o;
               state <= RESP;
            end
            RESP: if (|(resp_valid & resp_ready)) begin
               last <= grant_id;
               ops_done <= ops_done + CNT_W'(1);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
